// File: rtl/gs_window_ctrl_if.sv
// Pixel-stream control / window-strobe bundle between the camera pipeline
// source, the 2x2 greyscale window sequencer and the frame-buffer writer.
// Optional macro GS_FRAME_CNT_EN adds the 16-bit completed-frame counter.
interface gs_window_ctrl_if #(
    parameter int CW = 12
) ();
    logic          sof;
    logic          pix_valid;
    logic          err_clr;
    logic          gs_valid;
    logic [CW-2:0] gs_x;
    logic [CW-2:0] gs_y;
    logic          frame_done;
    logic          busy;
    logic [1:0]    err;
`ifdef GS_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    modport master (
        output sof, pix_valid, err_clr,
        input  gs_valid, gs_x, gs_y, frame_done, busy, err
`ifdef GS_FRAME_CNT_EN
        , input frame_cnt
`endif
    );

    modport slave (
        input  sof, pix_valid, err_clr,
        output gs_valid, gs_x, gs_y, frame_done, busy, err
`ifdef GS_FRAME_CNT_EN
        , output frame_cnt
`endif
    );
endinterface

// File: rtl/gs_window_ctrl.sv
// Sequencer for the 2x2 greyscale averaging datapath: tracks column/row of
// the incoming pixel stream, strobes gs_valid with half-resolution
// coordinates when the datapath holds an aligned 2x2 window, and flags
// broken pixel pairs and mid-frame restarts.
// Optional macro GS_FRAME_CNT_EN adds frame_cnt (completed frames, wraps).
//
// state      | meaning
// -----------+--------------------------------------------------------
// S_IDLE     | waiting for sof; pix_valid ignored
// S_EVEN_ROW | line-buffer fill row, no windows produced
// S_ODD_ROW  | window-producing row, even/odd pixel pairs must be adjacent
// S_DONE     | one cycle, frame_done asserted, then back to S_IDLE
module gs_window_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    gs_window_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EVEN_ROW = 2'd1,
        S_ODD_ROW  = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [CW-1:0] LP_COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LP_ROW_LAST = CW'(IMG_H - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic [CW-1:0] w_col_nxt;
    logic [CW-1:0] w_row_nxt;
    logic          r_even_acc;
    logic          w_even_nxt;
    logic          w_win;
    logic          w_pair_brk;
    logic          w_sof_err;
    logic          w_in_frame;
    logic          r_gs_valid;
    logic [CW-2:0] r_gs_x;
    logic [CW-2:0] r_gs_y;
    logic [1:0]    r_err;

    assign w_in_frame = (r_state == S_EVEN_ROW) || (r_state == S_ODD_ROW);

    // Next-state, counter advance and window / defect detection.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_even_nxt  = 1'b0;
        w_win       = 1'b0;
        w_pair_brk  = 1'b0;
        w_sof_err   = 1'b0;

        // The datapath shifts every clock, so a missing odd partner right
        // after an even pixel corrupts that window even if sof intervenes.
        if (r_even_acc && !bus.pix_valid) begin
            w_pair_brk = 1'b1;
        end

        if (bus.sof) begin
            // Restart from any state; sof in S_DONE is simply the next frame.
            w_sof_err   = w_in_frame;
            w_state_nxt = S_EVEN_ROW;
            w_row_nxt   = '0;
            w_col_nxt   = bus.pix_valid ? CW'(1) : '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_IDLE;
                end
                S_EVEN_ROW, S_ODD_ROW: begin
                    if (bus.pix_valid) begin
                        if (r_state == S_ODD_ROW) begin
                            w_even_nxt = ~r_col[0];
                            w_win      = r_even_acc;
                        end
                        if (r_col == LP_COL_LAST) begin
                            w_col_nxt = '0;
                            if (r_row == LP_ROW_LAST) begin
                                w_row_nxt   = '0;
                                w_state_nxt = S_DONE;
                            end else begin
                                w_row_nxt   = r_row + CW'(1);
                                w_state_nxt = (r_state == S_EVEN_ROW) ? S_ODD_ROW : S_EVEN_ROW;
                            end
                        end else begin
                            w_col_nxt = r_col + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Position counters, pending-pair flag, registered window strobe and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_even_acc <= 1'b0;
            r_gs_valid <= 1'b0;
            r_gs_x     <= '0;
            r_gs_y     <= '0;
            r_err      <= 2'b00;
        end else begin
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_even_acc <= w_even_nxt;
            r_gs_valid <= w_win;
            if (w_win) begin
                r_gs_x <= r_col[CW-1:1];
                r_gs_y <= r_row[CW-1:1];
            end
            // A new event in the clearing cycle still lands.
            r_err <= (bus.err_clr ? 2'b00 : r_err) | {w_sof_err, w_pair_brk};
        end
    end

    assign bus.gs_valid   = r_gs_valid;
    assign bus.gs_x       = r_gs_x;
    assign bus.gs_y       = r_gs_y;
    assign bus.frame_done = (r_state == S_DONE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.err        = r_err;

`ifdef GS_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Completed-frame counter; aborted frames never reach S_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 16'd0;
        end else if (r_state == S_DONE) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign bus.frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_gs_window_ctrl.sv
// Scoreboard bench for gs_window_ctrl on a 4x4 frame: the stimulus pushes
// expected windows and frame_done cycles, a negedge monitor pops and compares.
module tb_gs_window_ctrl;
    localparam int CW = 12;
    localparam int W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gs_window_ctrl_if #(.CW(CW)) bus();

    gs_window_ctrl #(.IMG_W(4), .IMG_H(4), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } win_t;

    win_t win_q[$];
    int   fd_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_win = 0;
    int   n_fd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: compare every presented window and frame_done against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.gs_valid) begin
                win_t e;
                n_win++;
                check("win_expected", int'(win_q.size() != 0), 1);
                if (win_q.size() != 0) begin
                    e = win_q.pop_front();
                    check("win_x", int'(bus.gs_x), e.x);
                    check("win_y", int'(bus.gs_y), e.y);
                    check("win_cycle", cyc, e.c);
                end
            end
            if (bus.frame_done) begin
                int ec;
                n_fd++;
                check("fd_expected", int'(fd_q.size() != 0), 1);
                if (fd_q.size() != 0) begin
                    ec = fd_q.pop_front();
                    check("fd_cycle", cyc, ec);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n_pix pixels of a 4x4 frame (sof on the first), gaps[i] idle cycles after pixel i.
    task automatic run_frame(input int gaps[16], input int n_pix);
        for (int idx = 0; idx < n_pix; idx++) begin
            int c;
            int col;
            int row;
            c             = cyc;
            col           = idx % W;
            row           = idx / W;
            bus.sof       = (idx == 0);
            bus.pix_valid = 1'b1;
            tick();
            bus.sof       = 1'b0;
            bus.pix_valid = 1'b0;
            if ((row % 2 == 1) && (col % 2 == 1) && (gaps[idx-1] == 0)) begin
                win_t w;
                w.x = col / 2;
                w.y = row / 2;
                w.c = c + 1;
                win_q.push_back(w);
            end
            if (idx == 15) fd_q.push_back(c + 1);
            for (int k = 0; k < gaps[idx]; k++) tick();
        end
    endtask

    task automatic check_frame_cnt(input string name, input int exp);
`ifdef GS_FRAME_CNT_EN
        check(name, int'(bus.frame_cnt), exp);
`endif
    endtask

    initial begin
        int g[16];
        int w0;
        int f0;

        bus.sof       = 1'b0;
        bus.pix_valid = 1'b0;
        bus.err_clr   = 1'b0;
        #1;
        check("rst_gs_valid", int'(bus.gs_valid), 0);
        check("rst_gs_x", int'(bus.gs_x), 0);
        check("rst_gs_y", int'(bus.gs_y), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_err", int'(bus.err), 0);
        check_frame_cnt("rst_frame_cnt", 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1: back-to-back frame
        w0 = n_win; f0 = n_fd;
        g = '{default: 0};
        run_frame(g, 16);
        repeat (3) tick();
        check("t1_windows", n_win - w0, 4);
        check("t1_frame_done", n_fd - f0, 1);
        check("t1_err", int'(bus.err), 0);
        check("t1_busy_idle", int'(bus.busy), 0);
        check_frame_cnt("t1_frame_cnt", 1);

        // 2: legal gaps in an even row and between odd-row pairs
        w0 = n_win; f0 = n_fd;
        g = '{default: 0};
        g[1] = 3; g[5] = 3; g[13] = 2;
        run_frame(g, 16);
        repeat (3) tick();
        check("t2_windows", n_win - w0, 4);
        check("t2_frame_done", n_fd - f0, 1);
        check("t2_err", int'(bus.err), 0);
        check_frame_cnt("t2_frame_cnt", 2);

        // 3: pair break after pixel (2,1)
        w0 = n_win; f0 = n_fd;
        g = '{default: 0};
        g[6] = 1;
        run_frame(g, 16);
        repeat (3) tick();
        check("t3_windows", n_win - w0, 3);
        check("t3_frame_done", n_fd - f0, 1);
        check("t3_err", int'(bus.err), 1);
        check_frame_cnt("t3_frame_cnt", 3);

        // 4: sof at pixel 9 aborts the frame, then a full frame
        w0 = n_win; f0 = n_fd;
        g = '{default: 0};
        run_frame(g, 9);
        run_frame(g, 16);
        repeat (3) tick();
        check("t4_windows", n_win - w0, 6);
        check("t4_frame_done", n_fd - f0, 1);
        check("t4_err", int'(bus.err), 3);
        check_frame_cnt("t4_frame_cnt", 4);

        // 5: pix_valid in IDLE without sof, then err_clr
        w0 = n_win; f0 = n_fd;
        bus.pix_valid = 1'b1;
        repeat (6) tick();
        check("t5_busy", int'(bus.busy), 0);
        bus.pix_valid = 1'b0;
        repeat (2) tick();
        check("t5_windows", n_win - w0, 0);
        check("t5_frame_done", n_fd - f0, 0);
        check("t5_err_before_clr", int'(bus.err), 3);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("t5_err_after_clr", int'(bus.err), 0);

        // 6: asynchronous reset in the middle of an odd row
        g = '{default: 0};
        g[4] = 1;
        run_frame(g, 7);
        check("t6_busy_pre", int'(bus.busy), 1);
        check("t6_err_pre", int'(bus.err), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", int'(bus.busy), 0);
        check("t6_rst_err", int'(bus.err), 0);
        check("t6_rst_gs_valid", int'(bus.gs_valid), 0);
        check("t6_rst_gs_x", int'(bus.gs_x), 0);
        check("t6_rst_gs_y", int'(bus.gs_y), 0);
        check("t6_rst_frame_done", int'(bus.frame_done), 0);
        check_frame_cnt("t6_rst_frame_cnt", 0);
        tick();
        rst_n = 1'b1;
        tick();
        w0 = n_win; f0 = n_fd;
        g = '{default: 0};
        run_frame(g, 16);
        repeat (3) tick();
        check("t6_windows", n_win - w0, 4);
        check("t6_frame_done", n_fd - f0, 1);
        check("t6_err", int'(bus.err), 0);
        check_frame_cnt("t6_frame_cnt", 1);

        check("end_win_q_empty", win_q.size(), 0);
        check("end_fd_q_empty", fd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
